fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the fetch PC, reads imem over req/ack,
// buffers 16-bit words in a small FIFO and hands them to the decoder.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   fetch_en            gate for issuing new memory requests
//   imem_req/addr       registered read request and word address
//   imem_ack/rdata      memory response (only honoured while imem_req=1)
//   redirect_valid/pc   flush buffer and in-flight fetch, refetch at pc
//   instr/instr_pc      buffer head (NOP 16'hB800 / pc 0 when empty)
//   instr_valid         buffer head valid
//   dec_ready           decoder consumes head this cycle
module fetch_unit #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              dec_ready
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [15:0] NOP = 16'hB800;

  typedef enum logic {
    S_FETCH,
    S_DROP
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [PW-1:0]     r_rd;
  logic [PW-1:0]     r_wr;
  logic [CW-1:0]     r_count;

  logic [15:0]       r_buf_data [BUF_DEPTH];
  logic [ADDR_W-1:0] r_buf_pc   [BUF_DEPTH];

  logic              w_ack;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic [CW-1:0]     w_count_nxt;
  logic              w_room;
  logic [ADDR_W-1:0] w_pc_inc;

  always_comb begin
    w_ack       = r_req & imem_ack;
    w_valid     = (r_count != '0);
    w_pop       = w_valid & dec_ready;
    w_push      = w_ack & (r_state == S_FETCH) & ~redirect_valid;
    w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    // Room is judged on the post-edge occupancy so a zero-wait memory
    // can keep one request per cycle in flight while the decoder drains.
    w_room      = (w_count_nxt < CW'(BUF_DEPTH));
    w_pc_inc    = r_addr + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_fetch_pc <= redirect_pc;
      // An unanswered request cannot be withdrawn: keep it on the bus
      // and throw its data away when it finally returns.
      if (r_req && !imem_ack) begin
        r_state <= S_DROP;
      end else begin
        r_state <= S_FETCH;
        r_req   <= fetch_en;
        r_addr  <= redirect_pc;
      end
    end else if (r_state == S_DROP) begin
      if (w_ack) begin
        r_state <= S_FETCH;
        r_req   <= fetch_en;
        r_addr  <= r_fetch_pc;
      end
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      r_count <= w_count_nxt;
      if (w_ack) r_fetch_pc <= w_pc_inc;
      // req/addr are frozen while a request waits for its ack.
      if (!r_req || imem_ack) begin
        r_req  <= fetch_en & w_room;
        r_addr <= w_ack ? w_pc_inc : r_fetch_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_buf_data[r_wr] <= imem_rdata;
      r_buf_pc[r_wr]   <= r_addr;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr_valid = w_valid;
  assign instr       = w_valid ? r_buf_data[r_rd] : NOP;
  assign instr_pc    = w_valid ? r_buf_pc[r_rd] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: zero-wait and slow memory,
// back-pressure, redirects, PC wrap and reset mid-request.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        dec_ready;

  logic        req2;
  logic [15:0] addr2;
  logic        ack2;
  logic [15:0] rdata2;
  logic        redir2 = 1'b0;
  logic [15:0] rpc2 = 16'h0000;
  logic [15:0] instr2;
  logic [15:0] pc2;
  logic        valid2;
  logic        ready2 = 1'b1;

  int tb_lat   = 0;
  int tb_wait  = 0;
  logic tb_stray = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .BUF_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .dec_ready(dec_ready)
  );

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'hFFFE), .BUF_DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_rdata(rdata2),
    .redirect_valid(redir2), .redirect_pc(rpc2),
    .instr(instr2), .instr_pc(pc2),
    .instr_valid(valid2), .dec_ready(ready2)
  );

  // Memory: mem[a] = 16'h4000 + a, ack after tb_lat waiting cycles.
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) tb_wait <= 0;
    else tb_wait <= tb_wait + 1;
  end

  assign imem_ack   = tb_stray | (imem_req && (tb_wait >= tb_lat));
  assign imem_rdata = 16'h4000 + imem_addr;
  assign ack2       = req2;
  assign rdata2     = 16'h4000 + addr2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    fetch_en = 1'b1; dec_ready = 1'b1; tb_lat = 0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL reset_req: got %b want 0", imem_req);
    end
    n_checks++;
    if (imem_addr !== 16'h0000) begin
      n_err++; $display("FAIL reset_addr: got %h want 0000", imem_addr);
    end
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== 16'hB800 || instr_pc !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_out: got v=%b i=%h pc=%h want v=0 i=b800 pc=0000",
               instr_valid, instr, instr_pc);
    end
    n_checks++;
    if (addr2 !== 16'hFFFE) begin
      n_err++; $display("FAIL reset_addr2: got %h want fffe", addr2);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero_wait();
    fetch_en = 1'b1; dec_ready = 1'b1; tb_lat = 0;
    do_reset();
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL zw_first: got req=%b addr=%h v=%b want 1 0000 0",
               imem_req, imem_addr, instr_valid);
    end
    for (int i = 0; i < 6; i++) begin
      logic [15:0] ei;
      ei = 16'h4000 + 16'(i);
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'(i) || instr !== ei) begin
        n_err++;
        $display("FAIL zw_seq%0d: got v=%b pc=%h i=%h want 1 %h %h",
                 i, instr_valid, instr_pc, instr, 16'(i), ei);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_pc [4];
    exp_pc[0] = 16'h0001; exp_pc[1] = 16'h0002;
    exp_pc[2] = 16'h0003; exp_pc[3] = 16'h0004;
    fetch_en = 1'b1; dec_ready = 1'b0; tb_lat = 0;
    do_reset();
    repeat (5) tick();
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL bp_req_low: got %b want 0", imem_req);
    end
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr !== 16'h4000) begin
      n_err++;
      $display("FAIL bp_head: got v=%b pc=%h i=%h want 1 0000 4000",
               instr_valid, instr_pc, instr);
    end
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i]) begin
        n_err++;
        $display("FAIL bp_drain%0d: got v=%b pc=%h want 1 %h",
                 i, instr_valid, instr_pc, exp_pc[i]);
      end
    end
  endtask

  task automatic test_fetch_en();
    fetch_en = 1'b1; dec_ready = 1'b0; tb_lat = 2;
    do_reset();
    tick();
    fetch_en = 1'b0;
    tick();
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_err++;
      $display("FAIL fe_hold: got req=%b addr=%h want 1 0000", imem_req, imem_addr);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL fe_done: got v=%b pc=%h req=%b want 1 0000 0",
               instr_valid, instr_pc, imem_req);
    end
    fetch_en = 1'b1; dec_ready = 1'b1; tb_lat = 0;
  endtask

  task automatic test_redirect_drop();
    bit seen;
    fetch_en = 1'b0; dec_ready = 1'b1; tb_lat = 3;
    do_reset();
    tick();
    fetch_en = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 16'h0005;
    tick();
    redirect_valid = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0005 || instr_valid !== 1'b0) begin
        n_err++;
        $display("FAIL drop_hold%0d: got req=%b addr=%h v=%b want 1 0005 0",
                 i, imem_req, imem_addr, instr_valid);
      end
      tick();
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0040 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drop_next: got req=%b addr=%h v=%b want 1 0040 0",
               imem_req, imem_addr, instr_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (instr_valid === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen || instr_pc !== 16'h0040 || instr !== 16'h4040) begin
      n_err++;
      $display("FAIL drop_first: got seen=%b pc=%h i=%h want 1 0040 4040",
               seen, instr_pc, instr);
    end
    tb_lat = 0;
  endtask

  task automatic test_back_to_back();
    fetch_en = 1'b1; dec_ready = 1'b1; tb_lat = 0;
    do_reset();
    repeat (4) tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0002 || imem_addr !== 16'h0003) begin
      n_err++;
      $display("FAIL b2b_pre: got v=%b pc=%h addr=%h want 1 0002 0003",
               instr_valid, instr_pc, imem_addr);
    end
    redirect_valid = 1'b1; redirect_pc = 16'h0080;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== 16'hB800 || imem_req !== 1'b1 ||
        imem_addr !== 16'h0080) begin
      n_err++;
      $display("FAIL b2b_flush: got v=%b i=%h req=%b addr=%h want 0 b800 1 0080",
               instr_valid, instr, imem_req, imem_addr);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0080 || instr !== 16'h4080) begin
      n_err++;
      $display("FAIL b2b_new0: got v=%b pc=%h i=%h want 1 0080 4080",
               instr_valid, instr_pc, instr);
    end
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0081) begin
      n_err++;
      $display("FAIL b2b_new1: got v=%b pc=%h want 1 0081", instr_valid, instr_pc);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc [4];
    logic [15:0] exp_i  [4];
    exp_pc[0] = 16'hFFFE; exp_i[0] = 16'h3FFE;
    exp_pc[1] = 16'hFFFF; exp_i[1] = 16'h3FFF;
    exp_pc[2] = 16'h0000; exp_i[2] = 16'h4000;
    exp_pc[3] = 16'h0001; exp_i[3] = 16'h4001;
    fetch_en = 1'b1; dec_ready = 1'b1; tb_lat = 0;
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (valid2 !== 1'b1 || pc2 !== exp_pc[i] || instr2 !== exp_i[i]) begin
        n_err++;
        $display("FAIL wrap%0d: got v=%b pc=%h i=%h want 1 %h %h",
                 i, valid2, pc2, instr2, exp_pc[i], exp_i[i]);
      end
    end
  endtask

  task automatic test_reset_outstanding();
    fetch_en = 1'b1; dec_ready = 1'b1; tb_lat = 3;
    do_reset();
    tick();
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_ack !== 1'b0) begin
      n_err++;
      $display("FAIL rst_pend: got req=%b ack=%b want 1 0", imem_req, imem_ack);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'hB800) begin
      n_err++;
      $display("FAIL rst_mid: got req=%b v=%b i=%h want 0 0 b800",
               imem_req, instr_valid, instr);
    end
    rst = 1'b0; fetch_en = 1'b0; tb_stray = 1'b1;
    tick();
    tick();
    tb_stray = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      n_err++;
      $display("FAIL rst_stray: got v=%b req=%b want 0 0", instr_valid, imem_req);
    end
    fetch_en = 1'b1; tb_lat = 0;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; dec_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_fetch_en();
    test_redirect_drop();
    test_back_to_back();
    test_wrap();
    test_reset_outstanding();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
